phase_lane_capture: RTL and testbench

- Downstream consumer of the phase-sequenced majority-vote tile.
- Takes its serial lane outputs (uo_out[4], uo_out[5]) and its ring-phase output (uo_out[2]) as frame marker.
- Deserialises each lane into a DEPTH-bit field, publishes the packed word with a one-cycle valid, and checks lane-to-lane agreement.
- Counts disagreeing frames and flags frames aborted by an early frame marker.

---
 rtl/phase_lane_capture.sv | 187 ++++++++++++++++++
 tb/tb_phase_lane_capture.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_lane_capture.sv
// phase_lane_capture: deserialises LANES serial lanes into DEPTH-bit fields per
// frame. A rising edge on phase_in (qualified by en) starts a frame. Each
// completed frame is published as a packed word with a one-cycle valid pulse,
// together with a lane-agreement flag. Disagreeing frames are counted, and
// frames cut short by an early frame marker set a sticky overrun flag.
module phase_lane_capture #(
  parameter int LANES = 2,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   phase_in,
  input  logic [LANES-1:0]       lane_in,
  input  logic                   clr_cnt,
  output logic [LANES*DEPTH-1:0] word_out,
  output logic                   word_valid,
  output logic                   agree,
  output logic [CNT_W-1:0]       err_cnt,
  output logic                   overrun,
  output logic                   busy
);

  localparam int W  = LANES * DEPTH;
  localparam int CW = $clog2(DEPTH);
  localparam logic [CW-1:0]    LAST    = CW'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } state_t;

  // True when every lane field of the packed word equals lane 0's field.
  function automatic logic fields_equal(input logic [W-1:0] w);
    logic eq;
    eq = 1'b1;
    for (int l = 1; l < LANES; l++) begin
      if (w[l*DEPTH +: DEPTH] != w[0 +: DEPTH]) begin
        eq = 1'b0;
      end
    end
    return eq;
  endfunction

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             phase_q;
  logic [W-1:0]     shift_q, shift_d;
  logic [W-1:0]     word_q, word_d;
  logic             valid_q, valid_d;
  logic             agree_q, agree_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             ovr_q, ovr_d;

  logic          start_s;
  logic          in_cap_s;
  logic          sample_s;
  logic          last_s;
  logic          abort_s;
  logic          eq_s;
  logic [CW-1:0] idx_s;

  // A new frame's first bit always lands at index 0, even when aborting.
  assign start_s  = phase_in & ~phase_q & en;
  assign in_cap_s = (state_q == CAPTURE);
  assign sample_s = en & (start_s | in_cap_s);
  assign abort_s  = start_s & in_cap_s;
  assign last_s   = sample_s & ~start_s & (cnt_q == LAST);
  assign idx_s    = start_s ? {CW{1'b0}} : cnt_q;
  assign eq_s     = fields_equal(shift_d);

  // Write the current lane bits into the shift field at the sample index.
  always_comb begin
    shift_d = shift_q;
    for (int l = 0; l < LANES; l++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (sample_s && (CW'(i) == idx_s)) begin
          shift_d[l*DEPTH+i] = lane_in[l];
        end else begin
          shift_d[l*DEPTH+i] = shift_q[l*DEPTH+i];
        end
      end
    end
  end

  // Frame FSM: next state and bit counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_s) begin
          state_d = CAPTURE;
          cnt_d   = CW'(1);
        end else begin
          state_d = IDLE;
          cnt_d   = cnt_q;
        end
      end
      CAPTURE: begin
        if (!en) begin
          state_d = CAPTURE;
          cnt_d   = cnt_q;
        end else if (start_s) begin
          state_d = CAPTURE;
          cnt_d   = CW'(1);
        end else if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = CAPTURE;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // Completion outputs, error counter and sticky overrun flag.
  always_comb begin
    word_d  = word_q;
    valid_d = last_s;
    agree_d = agree_q;
    err_d   = err_q;
    ovr_d   = ovr_q;
    if (last_s) begin
      word_d  = shift_d;
      agree_d = eq_s;
    end else begin
      word_d  = word_q;
      agree_d = agree_q;
    end
    if (clr_cnt) begin
      err_d = {CNT_W{1'b0}};
      ovr_d = 1'b0;
    end else begin
      if (last_s && !eq_s && (err_q != CNT_MAX)) begin
        err_d = err_q + CNT_W'(1);
      end else begin
        err_d = err_q;
      end
      if (abort_s) begin
        ovr_d = 1'b1;
      end else begin
        ovr_d = ovr_q;
      end
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      phase_q <= 1'b0;
      shift_q <= {W{1'b0}};
      word_q  <= {W{1'b0}};
      valid_q <= 1'b0;
      agree_q <= 1'b1;
      err_q   <= {CNT_W{1'b0}};
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_in;
      shift_q <= shift_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      agree_q <= agree_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign agree      = agree_q;
  assign err_cnt    = err_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q == CAPTURE);

endmodule

// File: tb/tb_phase_lane_capture.sv
// Testbench for phase_lane_capture: a frame-level reference model collects
// lane bits into integer values and pushes expected completions into a
// queue; a monitor pops and compares whenever the DUT pulses word_valid.
module tb_phase_lane_capture;

  localparam int LANES = 2;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int W     = LANES * DEPTH;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             phase_in;
  logic [LANES-1:0] lane_in;
  logic             clr_cnt;
  logic [W-1:0]     word_out;
  logic             word_valid;
  logic             agree;
  logic [CNT_W-1:0] err_cnt;
  logic             overrun;
  logic             busy;

  phase_lane_capture #(.LANES(LANES), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .phase_in(phase_in),
    .lane_in(lane_in), .clr_cnt(clr_cnt), .word_out(word_out),
    .word_valid(word_valid), .agree(agree), .err_cnt(err_cnt),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  typedef struct {
    logic [W-1:0] word;
    bit           agr;
    int           err;
  } exp_t;

  exp_t         exp_q[$];
  bit           m_prev, m_in_frame, m_ovr, m_valid_now, m_agree;
  int           m_nbits, m_err;
  int           m_vals[LANES];
  logic [W-1:0] m_word;

  task automatic model_reset();
    m_prev = 0; m_in_frame = 0; m_ovr = 0; m_valid_now = 0; m_agree = 1;
    m_nbits = 0; m_err = 0; m_word = '0;
    for (int l = 0; l < LANES; l++) m_vals[l] = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic e, input logic p, input logic [LANES-1:0] ln, input logic c);
    bit   start;
    bit   agr;
    exp_t x;
    if (!rst_n) begin
      model_reset();
      return;
    end
    start = p && !m_prev && e;
    m_prev = p;
    m_valid_now = 0;
    if (e) begin
      if (start) begin
        if (m_in_frame) m_ovr = 1;
        m_in_frame = 1;
        m_nbits = 0;
        for (int l = 0; l < LANES; l++) m_vals[l] = 0;
      end
      if (m_in_frame) begin
        for (int l = 0; l < LANES; l++) m_vals[l] += int'(ln[l]) << m_nbits;
        m_nbits++;
        if (m_nbits == DEPTH) begin
          m_in_frame = 0;
          agr = 1;
          m_word = '0;
          for (int l = 0; l < LANES; l++) begin
            if (m_vals[l] != m_vals[0]) agr = 0;
            m_word = m_word | (W'(m_vals[l]) << (l * DEPTH));
          end
          m_agree = agr;
          if (!agr && m_err < MAXC) m_err++;
          m_valid_now = 1;
        end
      end
    end
    if (c) begin
      m_err = 0;
      m_ovr = 0;
    end
    if (m_valid_now) begin
      x.word = m_word; x.agr = m_agree; x.err = m_err;
      exp_q.push_back(x);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic e, input logic p, input logic [LANES-1:0] ln, input logic c);
    @(negedge clk);
    en = e; phase_in = p; lane_in = ln; clr_cnt = c;
    model_step(e, p, ln, c);
  endtask

  task automatic frame(input logic [DEPTH-1:0] l0, input logic [DEPTH-1:0] l1, input logic clr_last);
    for (int i = 0; i < DEPTH; i++)
      drive(1'b1, (i == 0), {l1[i], l0[i]}, clr_last && (i == DEPTH - 1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, LANES'($urandom), 1'b0);
  endtask

  task automatic assert_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; phase_in = 1'b0; lane_in = '0; clr_cnt = 1'b0;
    model_reset();
    #1;
    chk("rst_word", word_out, 0);
    chk("rst_valid", word_valid, 0);
    chk("rst_agree", agree, 1);
    chk("rst_err", err_cnt, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_busy", busy, 0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1; phase_in = 1'b0; lane_in = '0; clr_cnt = 1'b0;
    model_step(1'b1, 1'b0, '0, 1'b0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      chk("busy", busy, m_in_frame);
      chk("err_cnt", err_cnt, m_err);
      chk("overrun", overrun, m_ovr);
      chk("valid_timing", word_valid, m_valid_now);
      chk("word_hold", word_out, m_word);
      chk("agree_hold", agree, m_agree);
      if (word_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_word", word_out, e.word);
          chk("sb_agree", agree, e.agr);
          chk("sb_err", err_cnt, e.err);
        end
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    logic p_cur;
    logic b;
    rst_n = 1'b0; en = 1'b0; phase_in = 1'b0; lane_in = '0; clr_cnt = 1'b0;
    model_reset();
    assert_reset();
    drive(1'b0, 1'b0, '0, 1'b0);
    release_reset();

    // Agreeing frame: both lanes 1,0,1,1.
    frame(4'b1101, 4'b1101, 1'b0);
    idle(2);
    chk("word_dd", word_out, 8'hDD);
    chk("agree_dd", agree, 1);

    // Disagreeing frame: lane1 1,1,0,0.
    frame(4'b1101, 4'b0011, 1'b0);
    idle(2);
    chk("word_3d", word_out, 8'h3D);
    chk("err_one", err_cnt, 1);

    // Early marker during bit 2 aborts the frame.
    drive(1'b1, 1'b1, 2'b11, 1'b0);
    drive(1'b1, 1'b0, 2'b00, 1'b0);
    drive(1'b1, 1'b1, 2'b01, 1'b0);
    drive(1'b1, 1'b0, 2'b10, 1'b0);
    drive(1'b1, 1'b0, 2'b11, 1'b0);
    drive(1'b1, 1'b0, 2'b00, 1'b0);
    idle(2);
    chk("ovr_set", overrun, 1);

    // Two en=0 cycles after bit 1 stretch the frame.
    drive(1'b1, 1'b1, 2'b11, 1'b0);
    drive(1'b1, 1'b0, 2'b00, 1'b0);
    drive(1'b0, 1'b0, 2'b01, 1'b0);
    drive(1'b0, 1'b0, 2'b10, 1'b0);
    drive(1'b1, 1'b0, 2'b11, 1'b0);
    drive(1'b1, 1'b0, 2'b11, 1'b0);
    idle(2);
    chk("word_stall", word_out, 8'hDD);
    // Rising marker while en=0 in IDLE is dropped.
    drive(1'b0, 1'b1, 2'b11, 1'b0);
    drive(1'b1, 1'b1, 2'b11, 1'b0);
    drive(1'b1, 1'b0, 2'b11, 1'b0);
    chk("no_capture", busy, 0);

    // Saturation of the error counter, back-to-back frames.
    for (int k = 0; k < 257; k++) frame(4'h1, 4'h2, 1'b0);
    idle(1);
    chk("err_sat", err_cnt, 8'hFF);
    // Clear coincident with a disagreeing completion.
    frame(4'h5, 4'hA, 1'b1);
    idle(1);
    chk("clr_err", err_cnt, 0);
    chk("clr_ovr", overrun, 0);

    // Reset in the middle of a frame.
    drive(1'b1, 1'b1, 2'b11, 1'b0);
    drive(1'b1, 1'b0, 2'b01, 1'b0);
    assert_reset();
    drive(1'b0, 1'b0, '0, 1'b0);
    release_reset();
    idle(6);

    // Randomised traffic with occasional stalls, clears, aborts and resets.
    p_cur = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 699) == 0) begin
        assert_reset();
        drive(1'b0, 1'b0, '0, 1'b0);
        release_reset();
        p_cur = 1'b0;
      end else begin
        if ($urandom_range(0, 3) == 0) p_cur = ~p_cur;
        b = 1'($urandom);
        drive(($urandom_range(0, 9) != 0), p_cur,
              ($urandom_range(0, 2) == 0) ? {b, b} : LANES'($urandom),
              ($urandom_range(0, 149) == 0));
      end
    end
    idle(DEPTH + 2);
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
